usb_rx_decoder: RTL and testbench

USB_RX_DECODER -- requirements
Module: usb_rx_decoder

---
 rtl/usb_rx_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_usb_rx_decoder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_decoder.sv
// USB full/low-speed receive decoder.
// Tracks SYNC on the raw line, NRZI-decodes and de-stuffs the data field into
// LSB-first bytes, validates EOP and reports packet completion with an error code.
// Also flags a timeout when the bus sits idle too long while receiving is enabled.
//
// Ports:
//   clock       single clock, all logic on posedge
//   reset_n     synchronous active-low reset
//   DP, DM      sampled bus line state, one per clock
//   rx_enable   high while the host is not driving the bus
//   byte_out    last received byte, held between strobes
//   byte_valid  one-cycle strobe qualifying byte_out
//   pkt_start   one-cycle strobe after a valid SYNC
//   pkt_done    one-cycle strobe at packet end, good or bad
//   pkt_error   qualifies pkt_done: packet bad
//   err_code    0 none, 1 stuff, 2 SE1, 3 alignment; nonzero only with pkt_done
//   rx_active   high whenever the receiver is not idle
//   rx_timeout  one-cycle strobe after TIMEOUT_CYCLES idle enabled cycles
module usb_rx_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       DP,
    input  logic       DM,
    input  logic       rx_enable,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       pkt_start,
    output logic       pkt_done,
    output logic       pkt_error,
    output logic [1:0] err_code,
    output logic       rx_active,
    output logic       rx_timeout
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] LineSe0 = 2'b00;
    localparam logic [1:0] LineK   = 2'b01;
    localparam logic [1:0] LineJ   = 2'b10;
    localparam logic [1:0] LineSe1 = 2'b11;

    // SYNC pattern K J K J K J K K, bit i set where symbol i is K.
    localparam logic [7:0] SyncIsK = 8'b1101_0101;

    localparam logic [1:0] ErrNone  = 2'd0;
    localparam logic [1:0] ErrStuff = 2'd1;
    localparam logic [1:0] ErrSe1   = 2'd2;
    localparam logic [1:0] ErrAlign = 2'd3;

    typedef enum logic [2:0] {StIdle, StSync, StData, StEop, StErr} state_e;

    state_e          state_q;
    logic [2:0]      sync_idx_q;
    logic [2:0]      bit_cnt_q;
    logic [2:0]      ones_q;
    logic            prev_k_q;   // previous J/K line state, 1 = K
    logic            align_q;    // EOP arrived mid-byte
    logic            eop_two_q;  // second SE0 already seen
    logic            se0_seen_q; // ERR: previous cycle was SE0
    logic [6:0]      shift_q;
    logic [TmoW-1:0] tmo_cnt_q;

    logic [1:0] line;
    logic       line_jk;
    logic       data_bit;
    logic       sync_ok;
    logic       err_det;
    logic [1:0] err_kind;

    assign line      = {DP, DM};
    assign line_jk   = DP ^ DM;
    assign data_bit  = ~(DM ^ prev_k_q);  // NRZI: no transition decodes as 1
    assign sync_ok   = (line == (SyncIsK[sync_idx_q] ? LineK : LineJ));
    assign rx_active = (state_q != StIdle);

    // Error detection in priority order SE1 > stuff > alignment.
    always_comb begin
        err_det  = 1'b0;
        err_kind = ErrNone;
        if (line == LineSe1 &&
            (state_q == StSync || state_q == StData || state_q == StEop)) begin
            err_det  = 1'b1;
            err_kind = ErrSe1;
        end else if (state_q == StData && line_jk && ones_q == 3'd6 && data_bit) begin
            err_det  = 1'b1;
            err_kind = ErrStuff;
        end else if (state_q == StEop &&
                     (line == LineK || (line == LineSe0 && eop_two_q))) begin
            err_det  = 1'b1;
            err_kind = ErrAlign;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            sync_idx_q <= '0;
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            prev_k_q   <= 1'b0;
            align_q    <= 1'b0;
            eop_two_q  <= 1'b0;
            se0_seen_q <= 1'b0;
            shift_q    <= '0;
            tmo_cnt_q  <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            pkt_start  <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_error  <= 1'b0;
            err_code   <= ErrNone;
            rx_timeout <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            pkt_start  <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_error  <= 1'b0;
            err_code   <= ErrNone;
            rx_timeout <= 1'b0;

            // A K in IDLE leaves IDLE, so it does not count as an idle cycle.
            if (rx_enable && state_q == StIdle && line != LineK) begin
                if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_cnt_q  <= '0;
                    rx_timeout <= 1'b1;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                end
            end else begin
                tmo_cnt_q <= '0;
            end

            if (!rx_enable) begin
                state_q <= StIdle;
            end else if (err_det) begin
                pkt_done   <= 1'b1;
                pkt_error  <= 1'b1;
                err_code   <= err_kind;
                state_q    <= StErr;
                se0_seen_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (line == LineK) begin
                            state_q    <= StSync;
                            sync_idx_q <= 3'd1;
                        end
                    end
                    StSync: begin
                        if (!sync_ok) begin
                            state_q <= StIdle;
                        end else if (sync_idx_q == 3'd7) begin
                            // The final K K pair is the first run of ones.
                            state_q   <= StData;
                            pkt_start <= 1'b1;
                            prev_k_q  <= 1'b1;
                            ones_q    <= 3'd1;
                            bit_cnt_q <= '0;
                            align_q   <= 1'b0;
                            eop_two_q <= 1'b0;
                        end else begin
                            sync_idx_q <= sync_idx_q + 3'd1;
                        end
                    end
                    StData: begin
                        if (line == LineSe0) begin
                            state_q   <= StEop;
                            eop_two_q <= 1'b0;
                            align_q   <= (bit_cnt_q != 3'd0);
                        end else begin
                            prev_k_q <= DM;
                            if (ones_q == 3'd6) begin
                                ones_q <= '0;  // stuffed zero, discarded
                            end else begin
                                ones_q    <= data_bit ? ones_q + 3'd1 : 3'd0;
                                shift_q   <= {data_bit, shift_q[6:1]};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    byte_out   <= {data_bit, shift_q};
                                    byte_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    StEop: begin
                        if (line == LineSe0) begin
                            eop_two_q <= 1'b1;
                        end else if (line == LineJ) begin
                            pkt_done  <= 1'b1;
                            pkt_error <= align_q;
                            err_code  <= align_q ? ErrAlign : ErrNone;
                            state_q   <= StIdle;
                        end
                    end
                    StErr: begin
                        se0_seen_q <= (line == LineSe0);
                        if (se0_seen_q && line == LineJ) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench for usb_rx_decoder.
// Packets are built as byte lists, encoded to line symbols by a bit-stuffing
// NRZI encoder, optionally corrupted, and the observed strobes are compared
// with what the packet-level rules predict.
module tb_usb_rx_decoder;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       DP = 1'b1;
    logic       DM = 1'b0;
    logic       rx_enable = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       pkt_start;
    logic       pkt_done;
    logic       pkt_error;
    logic [1:0] err_code;
    logic       rx_active;
    logic       rx_timeout;

    usb_rx_decoder #(
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .DP        (DP),
        .DM        (DM),
        .rx_enable (rx_enable),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .pkt_start (pkt_start),
        .pkt_done  (pkt_done),
        .pkt_error (pkt_error),
        .err_code  (err_code),
        .rx_active (rx_active),
        .rx_timeout(rx_timeout)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: collects strobes for the packet under test.
    logic [7:0] got_bytes[$];
    int         n_start = 0;
    int         n_done = 0;
    int         n_leak = 0;
    logic       last_err = 1'b0;
    logic [1:0] last_code = 2'd0;

    always @(posedge clock) begin
        #1;
        if (byte_valid) got_bytes.push_back(byte_out);
        if (pkt_start) n_start++;
        if (pkt_done) begin
            n_done++;
            last_err  = pkt_error;
            last_code = err_code;
        end
        if (!pkt_done && (pkt_error === 1'b1 || err_code !== 2'd0)) n_leak++;
    end

    logic [7:0] pkt_bytes[$];

    function automatic logic [1:0] sync_sym(input int i);
        return (i >= 6 || (i % 2) == 0) ? K : J;
    endfunction

    function automatic logic [1:0] flip(input logic [1:0] s);
        return (s == J) ? K : J;
    endfunction

    // Drive one symbol from a negedge; returns at the next negedge.
    task automatic play_sym(input logic [1:0] s);
        {DP, DM} = s;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) play_sym(J);
    endtask

    task automatic begin_pkt();
        got_bytes.delete();
        n_start = 0;
        n_done  = 0;
    endtask

    // SYNC then the first nbits data bits of pkt_bytes, LSB first, NRZI + stuffing.
    task automatic send_bits(input int nbits, input bit omit_stuff);
        logic [1:0] lvl;
        logic [7:0] b8;
        int         ones;
        bit         b;
        for (int i = 0; i < 8; i++) play_sym(sync_sym(i));
        lvl  = K;
        ones = 1;
        for (int i = 0; i < nbits; i++) begin
            b8 = pkt_bytes[i / 8];
            b  = b8[i % 8];
            if (!b) lvl = flip(lvl);
            play_sym(lvl);
            ones = b ? ones + 1 : 0;
            if (ones == 6 && !omit_stuff) begin
                lvl = flip(lvl);
                play_sym(lvl);
                ones = 0;
            end
        end
    endtask

    task automatic eop(input int n_se0);
        for (int i = 0; i < n_se0; i++) play_sym(SE0);
        play_sym(J);
    endtask

    task automatic check_pkt(input string name, input int exp_start, input int nexp,
                             input int exp_done, input logic exp_err,
                             input logic [1:0] exp_code, input bit chk_hold);
        chk({name, "_start"}, n_start, exp_start);
        chk({name, "_nbytes"}, got_bytes.size(), nexp);
        for (int i = 0; i < got_bytes.size() && i < nexp; i++)
            chk({name, "_byte"}, got_bytes[i], pkt_bytes[i]);
        chk({name, "_done"}, n_done, exp_done);
        if (exp_done > 0) begin
            chk({name, "_err"}, last_err, exp_err);
            chk({name, "_code"}, last_code, exp_code);
        end
        if (chk_hold && nexp > 0) chk({name, "_hold"}, byte_out, pkt_bytes[nexp - 1]);
    endtask

    task automatic good_pkt(input string name, input int nb);
        begin_pkt();
        send_bits(8 * nb, 1'b0);
        eop($urandom_range(1, 2));
        idle(4);
        check_pkt(name, 1, nb, 1, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int tmo_hits;
        int tmo_first;
        int kind;
        int nb;
        int k;
        int p;

        {DP, DM}  = J;
        reset_n   = 1'b0;
        rx_enable = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_pkt_start", pkt_start, 1'b0);
        chk("rst_pkt_done", pkt_done, 1'b0);
        chk("rst_pkt_error", pkt_error, 1'b0);
        chk("rst_err_code", err_code, 2'd0);
        chk("rst_rx_active", rx_active, 1'b0);
        chk("rst_rx_timeout", rx_timeout, 1'b0);
        reset_n = 1'b1;
        idle(3);

        pkt_bytes = '{8'hC3, 8'h00};
        good_pkt("c3_00", 2);

        pkt_bytes = '{8'hFF, 8'hFF};
        good_pkt("ff_ff", 2);

        // Stuff bit omitted: the sixth data 1 arrives where a stuffed 0 belongs.
        begin_pkt();
        send_bits(16, 1'b1);
        eop(2);
        idle(4);
        check_pkt("nostuff", 1, 0, 1, 1'b1, 2'd1, 1'b0);

        pkt_bytes = '{8'hA5};
        begin_pkt();
        send_bits(4, 1'b0);
        play_sym(SE1);
        play_sym(SE0);
        play_sym(J);
        chk("se1_recover_active", rx_active, 1'b0);
        idle(3);
        check_pkt("se1", 1, 0, 1, 1'b1, 2'd2, 1'b0);

        pkt_bytes = '{8'h81, 8'h7E, 8'h42};
        good_pkt("after_se1", 3);

        pkt_bytes = '{8'h5A, 8'h3C};
        begin_pkt();
        send_bits(12, 1'b0);
        eop(2);
        idle(4);
        check_pkt("trunc12", 1, 1, 1, 1'b1, 2'd3, 1'b1);

        begin_pkt();
        play_sym(K);
        play_sym(J);
        play_sym(K);
        play_sym(K);
        chk("sync_bad_active", rx_active, 1'b0);
        idle(4);
        check_pkt("sync_bad", 0, 0, 0, 1'b0, 2'd0, 1'b0);

        pkt_bytes = '{8'h12};
        good_pkt("after_sync_bad", 1);

        pkt_bytes = '{8'h96, 8'h11};
        begin_pkt();
        send_bits(11, 1'b0);
        rx_enable = 1'b0;
        play_sym(J);
        chk("drop_active", rx_active, 1'b0);
        rx_enable = 1'b1;
        idle(4);
        check_pkt("drop", 1, 1, 0, 1'b0, 2'd0, 1'b1);

        pkt_bytes = '{8'h33};
        begin_pkt();
        send_bits(3, 1'b0);
        reset_n = 1'b0;
        play_sym(J);
        chk("rst_mid_active", rx_active, 1'b0);
        chk("rst_mid_byte_out", byte_out, 8'h00);
        reset_n = 1'b1;
        idle(4);
        check_pkt("rst_mid", 1, 0, 0, 1'b0, 2'd0, 1'b0);

        // Timeout: clear the counter, then hold J with rx_enable high.
        rx_enable = 1'b0;
        play_sym(J);
        rx_enable = 1'b1;
        tmo_hits  = 0;
        tmo_first = 0;
        for (int i = 1; i <= 300; i++) begin
            play_sym(J);
            if (rx_timeout) begin
                tmo_hits++;
                if (tmo_first == 0) tmo_first = i;
            end
        end
        chk("timeout_count", tmo_hits, 1);
        chk("timeout_cycle", tmo_first, 255);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            nb   = $urandom_range(1, 3);
            pkt_bytes.delete();
            for (int i = 0; i < nb; i++)
                pkt_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            begin_pkt();
            case (kind)
                0: begin
                    send_bits(8 * nb, 1'b0);
                    eop($urandom_range(1, 2));
                    idle(4);
                    check_pkt("rnd_good", 1, nb, 1, 1'b0, 2'd0, 1'b1);
                end
                1: begin
                    k = $urandom_range(0, 8 * nb - 1);
                    send_bits(k, 1'b0);
                    play_sym(SE1);
                    play_sym(SE0);
                    play_sym(J);
                    idle(4);
                    check_pkt("rnd_se1", 1, k / 8, 1, 1'b1, 2'd2, 1'b1);
                end
                2: begin
                    k = $urandom_range(1, 8 * nb - 1);
                    if (k % 8 == 0) k = k - 1;
                    send_bits(k, 1'b0);
                    eop($urandom_range(1, 2));
                    idle(4);
                    check_pkt("rnd_trunc", 1, k / 8, 1, 1'b1, 2'd3, 1'b1);
                end
                3: begin
                    k = $urandom_range(0, 8 * nb - 1);
                    send_bits(k, 1'b0);
                    rx_enable = 1'b0;
                    play_sym(J);
                    chk("rnd_drop_active", rx_active, 1'b0);
                    rx_enable = 1'b1;
                    idle(4);
                    check_pkt("rnd_drop", 1, k / 8, 0, 1'b0, 2'd0, 1'b1);
                end
                default: begin
                    p = $urandom_range(1, 7);
                    for (int i = 0; i < p; i++) play_sym(sync_sym(i));
                    play_sym(flip(sync_sym(p)));
                    chk("rnd_sync_active", rx_active, 1'b0);
                    idle(4);
                    check_pkt("rnd_sync", 0, 0, 0, 1'b0, 2'd0, 1'b0);
                end
            endcase
        end

        chk("err_outside_done", n_leak, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
